raster_tri_scheduler: RTL and testbench
=======================================

Name: raster_tri_scheduler

Overview:
Sequences triangles from the vertex/clip stage into the single tile rasterizer, one triangle at a time, over one frame.
- Restarts the rasterizer through its reset input for each triangle.
- Holds that triangle's vertices stable while the rasterizer runs and waits for its done.
- Reports frame completion and a watchdog timeout.
- Sits between the triangle stream (valid/ready) and the rasterizer instance.

Parameters:
VERTEX_WIDTH, 16, width of each signed vertex component (x, y, z); matches the rasterizer.
TIMEOUT_CYCLES, 4096, maximum RUN cycles per triangle before it is aborted.
COUNT_WIDTH, 16, width of the per-frame triangle counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
frame_start  in  1  single-cycle pulse that begins a frame; honoured only in IDLE.
tri_valid  in  1  triangle available.
tri_ready  out  1  scheduler accepts a triangle this cycle.
tri_vertex  in  signed VERTEX_WIDTH x [3][3]  triangle; [v][0]=x, [v][1]=y, [v][2]=z.
tri_last  in  1  qualifies tri_vertex; marks the final triangle of the frame.
rast_rst  out  1  registered restart to the rasterizer's rst.
rast_vertex  out  signed VERTEX_WIDTH x [3][3]  registered vertices to the rasterizer.
rast_done  in  1  rasterizer done.
busy  out  1  high in every state except IDLE.
frame_done  out  1  one-cycle pulse when the frame finishes.
tri_count  out  COUNT_WIDTH  triangles retired (completed or aborted) this frame.
err_timeout  out  1  sticky; set when any triangle times out; cleared by frame_start.

Behaviour:
Clock and reset: one clock, clk. Reset is synchronous and active-high on rst; polarity and synchronicity are fixed.

Reset values:
- rast_rst=1, tri_ready=0, busy=0, frame_done=0, err_timeout=0.
- tri_count=0, rast_vertex all 0, state=IDLE.
- rst asserted mid-triangle aborts it immediately; frame_done is not pulsed.

States: IDLE, ACCEPT, LOAD, RUN, FINISH.
- IDLE:
  - rast_rst=1.
  - On frame_start: clear tri_count and err_timeout, then go to ACCEPT.
  - frame_start in any other state is ignored.
- ACCEPT:
  - tri_ready=1 (combinational from state); rast_rst=1.
  - On tri_valid&&tri_ready: latch tri_vertex into rast_vertex and tri_last into last_q, then go to LOAD.
  - tri_valid low: stay.
- LOAD:
  - rast_rst=1 for exactly one cycle with the new rast_vertex already stable.
  - Go to RUN; clear the watchdog counter to 0.
- RUN:
  - rast_rst=0. rast_vertex is held constant throughout RUN.
  - Watchdog increments each cycle.
  - rast_done sampled every RUN cycle. It is guaranteed 0 in the first RUN cycle because the rasterizer was held in reset.
  - rast_done=1: tri_count+1; go to FINISH if last_q, else ACCEPT.
  - Timeout: watchdog==TIMEOUT_CYCLES-1 and rast_done=0. Set err_timeout, tri_count+1, then take the same transition as done.
  - rast_done and the timeout in the same cycle count as done; err_timeout is not set.
  - rast_rst returns to 1 on the cycle after leaving RUN.
- FINISH: frame_done=1 for one cycle; go to IDLE.

Timing and widths:
- Minimum spacing between accepting triangle N and triangle N+1 is 2 + (rasterizer cycles) + 1. Accept cycles are not overlapped with RUN.
- tri_count wraps modulo 2^COUNT_WIDTH without flagging.
- Watchdog width is $clog2(TIMEOUT_CYCLES)+1.
- A frame always ends on a tri_last triangle. An empty frame is not supported; upstream must send at least one triangle.

Decomposition:
- Shared package raster_pkg holds:
  - the sched_state_t enum (IDLE, ACCEPT, LOAD, RUN, FINISH);
  - vertex_t (signed VERTEX_WIDTH);
  - the tri_t array type [3][3];
  - localparam IDX_X=0, IDX_Y=1, IDX_Z=2.
- The watchdog is small and stays inline. No sub-module is required.

Test Plan:
1. Single triangle: frame_start.
   - Triangle v0=(2,2,100), v1=(10,2,100), v2=(2,8,100) with tri_last=1, stub rasterizer asserting done 20 cycles after rast_rst falls.
   - Required: tri_ready high exactly 1 cycle before accept; rast_rst low for exactly the RUN cycles; frame_done pulses once; tri_count=1; err_timeout=0.
2. Back-to-back triangles: tri_valid held high with 3 triangles, last on the third, stub done after 5 cycles.
   - Required: each rast_vertex is held unchanged throughout its RUN; tri_ready high only in ACCEPT; rast_rst pulses high for at least 2 cycles between triangles; tri_count=3; one frame_done.
3. Backpressure: tri_valid low for 7 cycles while in ACCEPT.
   - Required: rast_rst stays 1, busy=1, and there is no state progress until tri_valid rises.
4. Timeout: TIMEOUT_CYCLES=16, stub never asserts done, tri_last=1.
   - Required: RUN lasts exactly 16 cycles; err_timeout=1; tri_count=1; frame_done pulses.
   - A following frame_start clears err_timeout to 0.
5. Done and timeout coincident: TIMEOUT_CYCLES=16, done on RUN cycle 16.
   - Required: err_timeout stays 0; tri_count=1.
6. Reset mid-RUN: rst asserted during RUN of a 2-triangle frame.
   - Required: next cycle all outputs at reset values, rast_rst=1, no frame_done.
   - A subsequent frame_start with 1 triangle completes normally.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared types for the raster front end: scheduler states and the vertex/triangle shapes
// handed between the triangle stream, the scheduler and the rasterizer.
// Ports: none (package).
package raster_pkg;

  localparam int RASTER_VERTEX_WIDTH = 16;

  // Component indices inside one vertex.
  localparam int IDX_X = 0;
  localparam int IDX_Y = 1;
  localparam int IDX_Z = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    LOAD   = 3'd2,
    RUN    = 3'd3,
    FINISH = 3'd4
  } sched_state_t;

  typedef logic signed [RASTER_VERTEX_WIDTH-1:0] vertex_t;

  // [vertex][component]
  typedef vertex_t tri_t [3][3];

endpackage

// File: rtl/raster_tri_scheduler.sv
// Purpose: feeds one triangle at a time from the valid/ready stream into the tile rasterizer,
//          restarting it per triangle and holding the vertices while it runs.
// Latency/backpressure: accept -> LOAD (1 cycle restart) -> RUN until done or watchdog;
//          tri_ready is only high in ACCEPT, so upstream stalls for the whole rasterizer run.
// Ports: clk/rst (sync, active-high); frame_start; tri_valid/tri_ready/tri_vertex/tri_last
//        (triangle stream); rast_rst/rast_vertex/rast_done (rasterizer side);
//        busy, frame_done, tri_count, err_timeout (status).
module raster_tri_scheduler
  import raster_pkg::*;
#(
  parameter int VERTEX_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_start,
  input  logic                           tri_valid,
  output logic                           tri_ready,
  input  logic signed [VERTEX_WIDTH-1:0] tri_vertex [3][3],
  input  logic                           tri_last,
  output logic                           rast_rst,
  output logic signed [VERTEX_WIDTH-1:0] rast_vertex [3][3],
  input  logic                           rast_done,
  output logic                           busy,
  output logic                           frame_done,
  output logic [COUNT_WIDTH-1:0]         tri_count,
  output logic                           err_timeout
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  sched_state_t state_q, state_d;

  logic signed [VERTEX_WIDTH-1:0] rast_vertex_q [3][3];
  logic signed [VERTEX_WIDTH-1:0] rast_vertex_d [3][3];

  logic                   last_q, last_d;
  logic                   rast_rst_q, rast_rst_d;
  logic [COUNT_WIDTH-1:0] tri_count_q, tri_count_d;
  logic                   err_timeout_q, err_timeout_d;
  logic [WD_W-1:0]        wd_q, wd_d;

  always_comb begin
    state_d       = state_q;
    rast_vertex_d = rast_vertex_q;
    last_d        = last_q;
    tri_count_d   = tri_count_q;
    err_timeout_d = err_timeout_q;
    wd_d          = wd_q;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          tri_count_d   = '0;
          err_timeout_d = 1'b0;
          state_d       = ACCEPT;
        end
      end
      ACCEPT: begin
        if (tri_valid) begin
          rast_vertex_d = tri_vertex;
          last_d        = tri_last;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        wd_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        wd_d = wd_q + WD_W'(1);
        // A done arriving on the final watchdog cycle wins: the triangle counts as completed.
        if (rast_done || (wd_q == WD_LAST)) begin
          tri_count_d = tri_count_q + COUNT_WIDTH'(1);
          if (!rast_done) begin
            err_timeout_d = 1'b1;
          end
          state_d = last_q ? FINISH : ACCEPT;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered restart: low exactly while the registered state is RUN, so the rasterizer
    // sees reset during LOAD with rast_vertex already stable and again right after RUN.
    rast_rst_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rast_vertex_q <= '{default: '0};
      last_q        <= 1'b0;
      rast_rst_q    <= 1'b1;
      tri_count_q   <= '0;
      err_timeout_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      rast_vertex_q <= rast_vertex_d;
      last_q        <= last_d;
      rast_rst_q    <= rast_rst_d;
      tri_count_q   <= tri_count_d;
      err_timeout_q <= err_timeout_d;
      wd_q          <= wd_d;
    end
  end

  assign tri_ready   = (state_q == ACCEPT);
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == FINISH);
  assign rast_rst    = rast_rst_q;
  assign rast_vertex = rast_vertex_q;
  assign tri_count   = tri_count_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_raster_tri_scheduler.sv
// Directed bench for raster_tri_scheduler: a 4096-cycle-watchdog instance for the normal,
// back-to-back, backpressure and reset cases, and a 16-cycle-watchdog instance for timeouts.
module tb_raster_tri_scheduler;
  import raster_pkg::*;

  localparam int VW = RASTER_VERTEX_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  tri_t tri_vertex;

  // Main instance (watchdog 4096)
  logic frame_start, tri_valid, tri_last, tri_ready;
  logic rast_rst, rast_done, busy, frame_done, err_timeout;
  tri_t rast_vertex;
  logic [15:0] tri_count;

  // Timeout instance (watchdog 16)
  logic t_frame_start, t_tri_valid, t_tri_last, t_tri_ready;
  logic t_rast_rst, t_rast_done, t_busy, t_frame_done, t_err_timeout;
  tri_t t_rast_vertex;
  logic [15:0] t_tri_count;

  raster_tri_scheduler #(.VERTEX_WIDTH(VW), .TIMEOUT_CYCLES(4096), .COUNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .tri_valid(tri_valid),
    .tri_ready(tri_ready), .tri_vertex(tri_vertex), .tri_last(tri_last),
    .rast_rst(rast_rst), .rast_vertex(rast_vertex), .rast_done(rast_done),
    .busy(busy), .frame_done(frame_done), .tri_count(tri_count), .err_timeout(err_timeout)
  );

  raster_tri_scheduler #(.VERTEX_WIDTH(VW), .TIMEOUT_CYCLES(16), .COUNT_WIDTH(16)) u_dut_to (
    .clk(clk), .rst(rst), .frame_start(t_frame_start), .tri_valid(t_tri_valid),
    .tri_ready(t_tri_ready), .tri_vertex(tri_vertex), .tri_last(t_tri_last),
    .rast_rst(t_rast_rst), .rast_vertex(t_rast_vertex), .rast_done(t_rast_done),
    .busy(t_busy), .frame_done(t_frame_done), .tri_count(t_tri_count), .err_timeout(t_err_timeout)
  );

  // Stub rasterizers: done on RUN cycle done_after (1-based); 0 means never.
  int done_after = 0, run_cnt = 0;
  int t_done_after = 0, t_run_cnt = 0;
  always @(posedge clk) begin
    run_cnt   <= rast_rst   ? 0 : run_cnt + 1;
    t_run_cnt <= t_rast_rst ? 0 : t_run_cnt + 1;
  end
  assign rast_done   = !rast_rst   && (done_after != 0)   && (run_cnt == done_after - 1);
  assign t_rast_done = !t_rast_rst && (t_done_after != 0) && (t_run_cnt == t_done_after - 1);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9*VW-1:0] pack(input tri_t t);
    logic [9*VW-1:0] r;
    r = '0;
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < 3; c++)
        r[(v*3+c)*VW +: VW] = t[v][c];
    return r;
  endfunction

  function automatic tri_t mk(input int x0, y0, z0, x1, y1, z1, x2, y2, z2);
    tri_t t;
    t[0][IDX_X] = VW'(x0); t[0][IDX_Y] = VW'(y0); t[0][IDX_Z] = VW'(z0);
    t[1][IDX_X] = VW'(x1); t[1][IDX_Y] = VW'(y1); t[1][IDX_Z] = VW'(z1);
    t[2][IDX_X] = VW'(x2); t[2][IDX_Y] = VW'(y2); t[2][IDX_Z] = VW'(z2);
    return t;
  endfunction

  // Monitor on the main instance, sampled on the falling edge.
  int   ready_cyc = 0, frd_cnt = 0, cur_run = 0, last_run = 0, cur_gap = 0, min_gap = 1000;
  bit   had_run = 0;
  logic prev_rst = 1'b1;
  tri_t held;
  always @(negedge clk) begin
    if (tri_ready === 1'b1) begin
      ready_cyc++;
      chk("ready_only_with_rast_rst", rast_rst, 1);
    end
    if (frame_done === 1'b1) frd_cnt++;
    if (rast_rst === 1'b0) begin
      if (prev_rst === 1'b1) begin
        held = rast_vertex;
        if (had_run && cur_gap < min_gap) min_gap = cur_gap;
      end else begin
        chk("vertex_held_in_run", pack(rast_vertex), pack(held));
      end
      cur_run++;
    end else begin
      if (prev_rst === 1'b0) begin
        last_run = cur_run;
        cur_run  = 0;
        had_run  = 1;
        cur_gap  = 1;
      end else begin
        cur_gap++;
      end
    end
    prev_rst = rast_rst;
  end

  task automatic send_tri(input tri_t t, input logic last);
    int n = 0;
    tri_vertex = t;
    tri_last   = last;
    tri_valid  = 1'b1;
    while (tri_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", tri_ready, 1);
    @(negedge clk);
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    while (frame_done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_frame_done_seen"}, frame_done, 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rast_rst"},    rast_rst, 1);
    chk({tag, "_tri_ready"},   tri_ready, 0);
    chk({tag, "_busy"},        busy, 0);
    chk({tag, "_frame_done"},  frame_done, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_tri_count"},   tri_count, 0);
    chk({tag, "_rast_vertex"}, pack(rast_vertex), 0);
  endtask

  initial begin
    tri_t t1, ta, tb, tc, td, te, tf;
    int n, run;

    t1 = mk(2, 2, 100, 10, 2, 100, 2, 8, 100);
    ta = mk(0, 0, 5, 16, 0, 5, 0, 16, 5);
    tb = mk(-5, 3, 7, 12, -4, 7, 3, 9, -1);
    tc = mk(100, 200, 300, -100, -200, -300, 7, 8, 9);
    td = mk(1, 1, 1, 30, 1, 1, 1, 30, -2);
    te = mk(4, 4, 4, 40, 4, 4, 4, 40, 4);
    tf = mk(-1, -2, -3, -4, -5, -6, -7, -8, -9);

    rst = 1'b1;
    frame_start = 1'b0; tri_valid = 1'b0; tri_last = 1'b0;
    t_frame_start = 1'b0; t_tri_valid = 1'b0; t_tri_last = 1'b0;
    tri_vertex = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    chk("reset_t_rast_rst", t_rast_rst, 1);
    chk("reset_t_busy", t_busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // 1: single triangle, done on RUN cycle 20
    done_after = 20; ready_cyc = 0; frd_cnt = 0;
    pulse_frame_start();
    chk("t1_busy_in_accept", busy, 1);
    send_tri(t1, 1'b1);
    tri_valid = 1'b0;
    chk("t1_vertex_in_load", pack(rast_vertex), pack(t1));
    chk("t1_rast_rst_in_load", rast_rst, 1);
    wait_frame("t1");
    chk("t1_ready_cycles", ready_cyc, 1);
    chk("t1_run_len", last_run, 20);
    chk("t1_frame_done_count", frd_cnt, 1);
    chk("t1_tri_count", tri_count, 1);
    chk("t1_err_timeout", err_timeout, 0);
    chk("t1_busy_after", busy, 0);

    // 2: back-to-back triangles with tri_valid held high
    done_after = 5; ready_cyc = 0; frd_cnt = 0; had_run = 0; min_gap = 1000;
    pulse_frame_start();
    chk("t2_tri_count_cleared", tri_count, 0);
    send_tri(ta, 1'b0);
    send_tri(tb, 1'b0);
    send_tri(tc, 1'b1);
    tri_valid = 1'b0;
    wait_frame("t2");
    chk("t2_tri_count", tri_count, 3);
    chk("t2_frame_done_count", frd_cnt, 1);
    chk("t2_ready_cycles", ready_cyc, 3);
    chk("t2_gap_ge2", (min_gap >= 2 && min_gap < 1000), 1);
    chk("t2_run_len", last_run, 5);
    chk("t2_last_vertex", pack(rast_vertex), pack(tc));

    // 3: backpressure, tri_valid low for 7 ACCEPT cycles
    done_after = 3; frd_cnt = 0;
    pulse_frame_start();
    for (int i = 0; i < 7; i++) begin
      chk("t3_stall_ready", tri_ready, 1);
      chk("t3_stall_busy", busy, 1);
      chk("t3_stall_rast_rst", rast_rst, 1);
      chk("t3_stall_vertex", pack(rast_vertex), pack(tc));
      @(negedge clk);
    end
    send_tri(td, 1'b1);
    tri_valid = 1'b0;
    chk("t3_vertex_loaded", pack(rast_vertex), pack(td));
    wait_frame("t3");
    chk("t3_tri_count", tri_count, 1);
    chk("t3_frame_done_count", frd_cnt, 1);

    // 4: timeout with a rasterizer that never finishes (watchdog 16)
    t_done_after = 0;
    tri_vertex = t1;
    t_frame_start = 1'b1; t_tri_valid = 1'b1; t_tri_last = 1'b1;
    @(negedge clk);
    t_frame_start = 1'b0;
    chk("t4_ready", t_tri_ready, 1);
    @(negedge clk);
    t_tri_valid = 1'b0;
    n = 0; run = 0;
    while (t_frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (t_rast_rst === 1'b0) run++;
    end
    chk("t4_frame_done_seen", t_frame_done, 1);
    chk("t4_run_len", run, 16);
    chk("t4_err_timeout", t_err_timeout, 1);
    chk("t4_tri_count", t_tri_count, 1);
    @(negedge clk);
    chk("t4_frame_done_one_cycle", t_frame_done, 0);
    chk("t4_err_sticky_idle", t_err_timeout, 1);
    t_frame_start = 1'b1;
    @(negedge clk);
    t_frame_start = 1'b0;
    chk("t4_err_cleared", t_err_timeout, 0);
    chk("t4_count_cleared", t_tri_count, 0);

    // 5: done coincident with the last watchdog cycle
    t_done_after = 16;
    t_tri_valid = 1'b1; t_tri_last = 1'b1;
    @(negedge clk);
    t_tri_valid = 1'b0;
    n = 0; run = 0;
    while (t_frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (t_rast_rst === 1'b0) run++;
    end
    chk("t5_frame_done_seen", t_frame_done, 1);
    chk("t5_run_len", run, 16);
    chk("t5_err_timeout", t_err_timeout, 0);
    chk("t5_tri_count", t_tri_count, 1);

    // 6: reset in the middle of RUN of a 2-triangle frame
    @(negedge clk);
    done_after = 10; frd_cnt = 0;
    pulse_frame_start();
    send_tri(te, 1'b0);
    tri_valid = 1'b0;
    n = 0;
    while (rast_rst !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_run", rast_rst, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("t6_after_rst");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_no_frame_done", frd_cnt, 0);
    chk("t6_idle_after_rst", busy, 0);
    pulse_frame_start();
    send_tri(tf, 1'b1);
    tri_valid = 1'b0;
    wait_frame("t6");
    chk("t6_tri_count", tri_count, 1);
    chk("t6_err_timeout", err_timeout, 0);
    chk("t6_frame_done_count", frd_cnt, 1);
    chk("t6_vertex", pack(rast_vertex), pack(tf));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

endmodule
